reg_wb_arbiter: RTL and testbench

REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

---
 rtl/reg_wb_arbiter.sv | 157 +++++++++++++++
 tb/tb_reg_wb_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_wb_arbiter.sv
// ---------------------------------------------------------------------------
// reg_wb_arbiter
//
// Purpose:
//   Arbitrates register-file writeback between the main pipeline (requester 0)
//   and a multi-cycle execution unit (requester 1). It grants one requester
//   per cycle using a two-entry round-robin pointer and drives a registered
//   register-file write port.
//
//   It also keeps a pending-destination scoreboard (busy). An accepted issue
//   marks its destination pending. A requester-1 completion clears that mark.
//   Source addresses can be checked against the scoreboard for hazards.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   req0_valid/wa/wd, req0_ready     pipeline writeback request and grant
//   req1_valid/wa/wd, req1_ready     multi-cycle completion request and grant
//   issue_valid, issue_rd            multi-cycle issue marking issue_rd pending
//   issue_ready                      issue_rd is not pending
//   chk_adr1, chk_adr2, hazard       source hazard check against the scoreboard
//   rf_en, rf_wa, rf_wd              registered register-file write port
// ---------------------------------------------------------------------------
module reg_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_wa,
  input  logic [DATA_W-1:0] req0_wd,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_wa,
  input  logic [DATA_W-1:0] req1_wd,
  output logic              req1_ready,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              issue_ready,
  input  logic [ADDR_W-1:0] chk_adr1,
  input  logic [ADDR_W-1:0] chk_adr2,
  output logic              hazard,
  output logic              rf_en,
  output logic [ADDR_W-1:0] rf_wa,
  output logic [DATA_W-1:0] rf_wd
);

  // ptr_reg = 0 prefers requester 0 on contention, 1 prefers requester 1.
  logic              ptr_reg;
  logic              grant0;
  logic              grant1;

  logic              wr_fire;
  logic [ADDR_W-1:0] wr_wa;
  logic [DATA_W-1:0] wr_wd;

  logic [NREG-1:0]   busy_reg;
  logic [NREG-1:0]   busy_next;
  logic [NREG-1:0]   set_vec;
  logic [NREG-1:0]   clr_vec;
  logic [NREG-1:0]   sel_issue;
  logic [NREG-1:0]   sel_chk1;
  logic [NREG-1:0]   sel_chk2;
  logic              busy_issue;
  logic              issue_fire;

  // -------------------------------------------------------------------------
  // Grant logic. Grants are combinational. They are gated by rst_n so that
  // all ready outputs stay low while reset is held.
  // -------------------------------------------------------------------------
  always_comb begin
    grant0 = rst_n & req0_valid & (~req1_valid | ~ptr_reg);
    grant1 = rst_n & req1_valid & (~req0_valid |  ptr_reg);
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Writeback selection. A transfer to x0 is still granted, but it never
  // produces a write strobe.
  always_comb begin
    wr_wa = req0_wa;
    wr_wd = req0_wd;
    if (grant1) begin
      wr_wa = req1_wa;
      wr_wd = req1_wd;
    end
    wr_fire = (grant0 | grant1) & (wr_wa != '0);
  end

  // Round-robin pointer. After a transfer it points at the other requester.
  // It holds its value when no transfer occurs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= 1'b0;
    end else if (grant0) begin
      ptr_reg <= 1'b1;
    end else if (grant1) begin
      ptr_reg <= 1'b0;
    end
  end

  // Registered write port. The address and data hold between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_en <= 1'b0;
      rf_wa <= '0;
      rf_wd <= '0;
    end else begin
      rf_en <= wr_fire;
      if (wr_fire) begin
        rf_wa <= wr_wa;
        rf_wd <= wr_wd;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Scoreboard. Each bit has its own set, clear and lookup terms.
  // Bit 0 is never set, so x0 can never look pending.
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_sb
      if (gi == 0) begin : g_zero
        assign set_vec[gi] = 1'b0;
      end else begin : g_nz
        assign set_vec[gi] = issue_fire & (issue_rd == ADDR_W'(gi));
      end
      assign clr_vec[gi]   = grant1 & (req1_wa == ADDR_W'(gi));
      assign sel_issue[gi] = busy_reg[gi] & (issue_rd == ADDR_W'(gi));
      assign sel_chk1[gi]  = busy_reg[gi] & (chk_adr1 == ADDR_W'(gi));
      assign sel_chk2[gi]  = busy_reg[gi] & (chk_adr2 == ADDR_W'(gi));
    end
  endgenerate

  always_comb begin
    busy_issue  = |sel_issue;
    issue_ready = rst_n & ~busy_issue;
    issue_fire  = issue_valid & issue_ready;
    // When a set and a clear hit the same bit in one cycle, the set wins.
    // The newly issued operation still owns that register.
    busy_next   = (busy_reg & ~clr_vec) | set_vec;
    hazard      = ((chk_adr1 != '0) & (|sel_chk1)) |
                  ((chk_adr2 != '0) & (|sel_chk2));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_wb_arbiter
//
// Purpose:
//   Directed self-checking bench for reg_wb_arbiter. Inputs change on the
//   falling clock edge. Combinational outputs are sampled 1 time unit later.
//   Registered outputs are sampled on the next falling edge.
// ---------------------------------------------------------------------------
module tb_reg_wb_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 32;

  logic              clk;
  logic              rst_n;
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_wa;
  logic [DATA_W-1:0] req0_wd;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_wa;
  logic [DATA_W-1:0] req1_wd;
  logic              req1_ready;
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_rd;
  logic              issue_ready;
  logic [ADDR_W-1:0] chk_adr1;
  logic [ADDR_W-1:0] chk_adr2;
  logic              hazard;
  logic              rf_en;
  logic [ADDR_W-1:0] rf_wa;
  logic [DATA_W-1:0] rf_wd;

  int checks;
  int errors;

  reg_wb_arbiter #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .NREG  (NREG)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_wa    (req0_wa),
    .req0_wd    (req0_wd),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_wa    (req1_wa),
    .req1_wd    (req1_wd),
    .req1_ready (req1_ready),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .issue_ready(issue_ready),
    .chk_adr1   (chk_adr1),
    .chk_adr2   (chk_adr2),
    .hazard     (hazard),
    .rf_en      (rf_en),
    .rf_wa      (rf_wa),
    .rf_wd      (rf_wd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: the bench must always terminate on its own.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // -------------------------------------------------------------------------
  task automatic test_reset();
    rst_n       = 1'b0;
    req0_valid  = 1'b1;
    req0_wa     = 5'd3;
    req0_wd     = 32'h1111_1111;
    req1_valid  = 1'b1;
    req1_wa     = 5'd4;
    req1_wd     = 32'h2222_2222;
    issue_valid = 1'b1;
    issue_rd    = 5'd3;
    chk_adr1    = 5'd3;
    chk_adr2    = 5'd4;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_req0_ready got %b want 0", req0_ready); end
    checks++;
    if (req1_ready !== 1'b0) begin errors++; $display("FAIL reset_req1_ready got %b want 0", req1_ready); end
    checks++;
    if (issue_ready !== 1'b0) begin errors++; $display("FAIL reset_issue_ready got %b want 0", issue_ready); end
    checks++;
    if (rf_en !== 1'b0 || rf_wa !== 5'd0 || rf_wd !== 32'd0) begin
      errors++;
      $display("FAIL reset_rf got en=%b wa=%0d wd=%h want en=0 wa=0 wd=0", rf_en, rf_wa, rf_wd);
    end
    checks++;
    if (hazard !== 1'b0) begin errors++; $display("FAIL reset_hazard got %b want 0", hazard); end
    @(negedge clk);
    req0_valid  = 1'b0;
    req1_valid  = 1'b0;
    issue_valid = 1'b0;
    chk_adr1    = 5'd0;
    chk_adr2    = 5'd0;
    rst_n       = 1'b1;
    $display("reset: released");
  endtask

  // -------------------------------------------------------------------------
  task automatic test_single();
    @(negedge clk);
    req0_valid = 1'b1;
    req0_wa    = 5'd5;
    req0_wd    = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_grant got r0=%b r1=%b want r0=1 r1=0", req0_ready, req1_ready);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    checks++;
    if (rf_en !== 1'b1 || rf_wa !== 5'd5 || rf_wd !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL single_write got en=%b wa=%0d wd=%h want en=1 wa=5 wd=deadbeef", rf_en, rf_wa, rf_wd);
    end
    $display("single: req0 wa=%0d wd=%h -> rf_en=%b", rf_wa, rf_wd, rf_en);
    @(negedge clk);
    checks++;
    if (rf_en !== 1'b0 || rf_wa !== 5'd5 || rf_wd !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL single_hold got en=%b wa=%0d wd=%h want en=0 wa=5 wd=deadbeef", rf_en, rf_wa, rf_wd);
    end
  endtask

  // -------------------------------------------------------------------------
  // Both requesters stay valid for four cycles after a fresh reset.
  // Grant i goes to requester i%2 and carries wa=i+1.
  // Its wd is 0xA0+i for requester 0 and 0xB0+i for requester 1.
  task automatic test_round_robin();
    logic [DATA_W-1:0] exp_wd;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_wa = 5'd1; req0_wd = 32'hA0;
    req1_valid = 1'b1; req1_wa = 5'd2; req1_wd = 32'hB1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin
        errors++;
        $display("FAIL rr_grant%0d got r0=%b r1=%b want r0=%0d r1=%0d",
                 i, req0_ready, req1_ready, (i % 2 == 0), (i % 2 == 1));
      end
      @(negedge clk);
      exp_wd = (i % 2 == 0) ? DATA_W'(32'hA0 + i) : DATA_W'(32'hB0 + i);
      checks++;
      if (rf_en !== 1'b1 || rf_wa !== ADDR_W'(i + 1) || rf_wd !== exp_wd) begin
        errors++;
        $display("FAIL rr_write%0d got en=%b wa=%0d wd=%h want en=1 wa=%0d wd=%h",
                 i, rf_en, rf_wa, rf_wd, i + 1, exp_wd);
      end
      $display("rr: grant %0d wa=%0d wd=%h", i, rf_wa, rf_wd);
      case (i)
        0: begin req0_wa = 5'd3; req0_wd = 32'hA2; end
        1: begin req1_wa = 5'd4; req1_wd = 32'hB3; end
        2: begin req0_wa = 5'd5; req0_wd = 32'hA4; end
        default: begin req0_valid = 1'b0; req1_valid = 1'b0; end
      endcase
    end
    @(negedge clk);
    checks++;
    if (rf_en !== 1'b0) begin errors++; $display("FAIL rr_idle got en=%b want 0", rf_en); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_scoreboard();
    @(negedge clk);
    issue_valid = 1'b1;
    issue_rd    = 5'd7;
    #1;
    checks++;
    if (issue_ready !== 1'b1) begin errors++; $display("FAIL sb_issue_ready got %b want 1", issue_ready); end
    @(negedge clk);
    issue_valid = 1'b0;
    chk_adr1    = 5'd7;
    #1;
    checks++;
    if (hazard !== 1'b1) begin errors++; $display("FAIL sb_hazard_set got %b want 1", hazard); end
    checks++;
    if (issue_ready !== 1'b0) begin errors++; $display("FAIL sb_issue_blocked got %b want 0", issue_ready); end
    $display("sb: issue rd=7 hazard=%b issue_ready=%b", hazard, issue_ready);
    // Swap which check port sees register 7.
    chk_adr1 = 5'd0;
    chk_adr2 = 5'd7;
    #1;
    checks++;
    if (hazard !== 1'b1) begin errors++; $display("FAIL sb_hazard_adr2 got %b want 1", hazard); end
    req1_valid = 1'b1;
    req1_wa    = 5'd7;
    req1_wd    = 32'h0000_0077;
    #1;
    checks++;
    if (req1_ready !== 1'b1) begin errors++; $display("FAIL sb_req1_ready got %b want 1", req1_ready); end
    @(negedge clk);
    req1_valid = 1'b0;
    #1;
    checks++;
    if (hazard !== 1'b0 || issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL sb_cleared got hazard=%b issue_ready=%b want 0 1", hazard, issue_ready);
    end
    checks++;
    if (rf_en !== 1'b1 || rf_wa !== 5'd7 || rf_wd !== 32'h77) begin
      errors++;
      $display("FAIL sb_req1_write got en=%b wa=%0d wd=%h want en=1 wa=7 wd=77", rf_en, rf_wa, rf_wd);
    end
    $display("sb: req1 completion wa=7 hazard=%b", hazard);
    chk_adr2 = 5'd0;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_set_clear_same();
    @(negedge clk);
    req1_valid  = 1'b1;
    req1_wa     = 5'd9;
    req1_wd     = 32'h0000_0099;
    issue_valid = 1'b1;
    issue_rd    = 5'd9;
    #1;
    checks++;
    if (issue_ready !== 1'b1 || req1_ready !== 1'b1) begin
      errors++;
      $display("FAIL sc_accept got issue_ready=%b r1=%b want 1 1", issue_ready, req1_ready);
    end
    @(negedge clk);
    req1_valid  = 1'b0;
    issue_valid = 1'b0;
    chk_adr1    = 5'd9;
    #1;
    checks++;
    if (hazard !== 1'b1 || issue_ready !== 1'b0) begin
      errors++;
      $display("FAIL sc_set_wins got hazard=%b issue_ready=%b want 1 0", hazard, issue_ready);
    end
    checks++;
    if (rf_en !== 1'b1 || rf_wa !== 5'd9 || rf_wd !== 32'h99) begin
      errors++;
      $display("FAIL sc_write got en=%b wa=%0d wd=%h want en=1 wa=9 wd=99", rf_en, rf_wa, rf_wd);
    end
    $display("sc: set+clear rd=9 hazard=%b", hazard);
    // An issue to x0 must leave the scoreboard unchanged.
    issue_valid = 1'b1;
    issue_rd    = 5'd0;
    chk_adr1    = 5'd0;
    chk_adr2    = 5'd9;
    @(negedge clk);
    issue_valid = 1'b0;
    #1;
    checks++;
    if (hazard !== 1'b1) begin errors++; $display("FAIL sc_x0_keep9 got %b want 1", hazard); end
    chk_adr2 = 5'd0;
    #1;
    checks++;
    if (hazard !== 1'b0) begin errors++; $display("FAIL sc_x0_nohazard got %b want 0", hazard); end
    // A write to x0 is granted but never strobed.
    req0_valid = 1'b1;
    req0_wa    = 5'd0;
    req0_wd    = 32'h0000_1234;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin errors++; $display("FAIL x0_ready got %b want 1", req0_ready); end
    @(negedge clk);
    req0_valid = 1'b0;
    checks++;
    if (rf_en !== 1'b0 || rf_wa !== 5'd9 || rf_wd !== 32'h99) begin
      errors++;
      $display("FAIL x0_no_write got en=%b wa=%0d wd=%h want en=0 wa=9 wd=99", rf_en, rf_wa, rf_wd);
    end
    $display("x0: req0 wa=0 granted, rf_en=%b", rf_en);
  endtask

  // -------------------------------------------------------------------------
  // Register 9 is still pending at this point.
  task automatic test_async_reset();
    int pulses;
    @(negedge clk);
    req0_valid = 1'b1;
    req0_wa    = 5'd3;
    req0_wd    = 32'h0000_0033;
    issue_rd   = 5'd9;
    chk_adr2   = 5'd9;
    @(posedge clk);
    #2;
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    req1_wa    = 5'd10;
    checks++;
    if (rf_en !== 1'b1 || hazard !== 1'b1) begin
      errors++;
      $display("FAIL ar_pre got en=%b hazard=%b want 1 1", rf_en, hazard);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rf_en !== 1'b0 || rf_wa !== 5'd0 || rf_wd !== 32'd0) begin
      errors++;
      $display("FAIL ar_rf got en=%b wa=%0d wd=%h want 0 0 0", rf_en, rf_wa, rf_wd);
    end
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || issue_ready !== 1'b0 || hazard !== 1'b0) begin
      errors++;
      $display("FAIL ar_outputs got r0=%b r1=%b ir=%b hz=%b want 0 0 0 0",
               req0_ready, req1_ready, issue_ready, hazard);
    end
    $display("async reset: rf_en=%b hazard=%b", rf_en, hazard);
    @(negedge clk);
    req1_valid = 1'b0;
    rst_n      = 1'b1;
    #1;
    checks++;
    if (hazard !== 1'b0 || issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL ar_busy_cleared got hazard=%b issue_ready=%b want 0 1", hazard, issue_ready);
    end
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rf_en !== 1'b0) pulses++;
    end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL ar_no_pulse got %0d pulses want 0", pulses); end
    chk_adr2 = 5'd0;
  endtask

  // -------------------------------------------------------------------------
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_scoreboard();
    test_set_clear_same();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
